// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage RV32I core.
// Captures the decoded bundle from ID and presents it to EX one cycle later.
// Inserts one bubble per load-use hazard. Turns a taken branch or jump
// resolved in EX into a bubble plus an IF/ID flush. Keeps saturating
// bubble and flush counters for performance debug.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,

  input  logic             have_inst_ID,
  input  logic [31:0]      pc_ID,
  input  logic [31:0]      rD1_ID,
  input  logic [31:0]      rD2_ID,
  input  logic [31:0]      ext_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       wR_ID,
  input  logic             rs1_re_ID,
  input  logic             rs2_re_ID,
  input  logic             rf_we_ID,
  input  logic [2:0]       rf_wsel_ID,
  input  logic [3:0]       alu_op_ID,
  input  logic             alu_sel1_ID,
  input  logic             alu_sel2_ID,
  input  logic             dram_we_ID,
  input  logic [1:0]       npc_op_ID,
  input  logic [1:0]       store_op_ID,

  input  logic             flush_EX,
  input  logic             mem_stall,

  output logic             have_inst_EX,
  output logic [31:0]      pc_EX,
  output logic [31:0]      rD1_EX,
  output logic [31:0]      rD2_EX,
  output logic [31:0]      ext_EX,
  output logic [4:0]       wR_EX,
  output logic             rf_we_EX,
  output logic [2:0]       rf_wsel_EX,
  output logic [3:0]       alu_op_EX,
  output logic             alu_sel1_EX,
  output logic             alu_sel2_EX,
  output logic             dram_we_EX,
  output logic [1:0]       npc_op_EX,
  output logic [1:0]       store_op_EX,

  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             flush_IFID,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             r_have_inst;
  logic [31:0]      r_pc;
  logic [31:0]      r_rD1;
  logic [31:0]      r_rD2;
  logic [31:0]      r_ext;
  logic [4:0]       r_wR;
  logic             r_rf_we;
  logic [2:0]       r_rf_wsel;
  logic [3:0]       r_alu_op;
  logic             r_alu_sel1;
  logic             r_alu_sel2;
  logic             r_dram_we;
  logic [1:0]       r_npc_op;
  logic [1:0]       r_store_op;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_wsel;
  logic w_ld_EX;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_lu;
  logic w_take_flush;
  logic w_take_bubble;
  logic w_insert_bubble;

  // Writeback selects that source the result from data memory (load variants).
  always_comb begin
    w_load_wsel = 1'b0;
    case (r_rf_wsel)
      3'b010, 3'b100, 3'b101, 3'b110, 3'b111: w_load_wsel = 1'b1;
      default:                                w_load_wsel = 1'b0;
    endcase
  end

  // Load-use detection. A load to x0 never stalls because x0 is never written.
  always_comb begin
    w_ld_EX   = r_have_inst & r_rf_we & w_load_wsel;
    w_rs1_hit = rs1_re_ID & (rs1_ID == r_wR);
    w_rs2_hit = rs2_re_ID & (rs2_ID == r_wR);
    w_lu      = w_ld_EX & have_inst_ID & (r_wR != 5'd0) & (w_rs1_hit | w_rs2_hit);
  end

  // Hazard resolution. A freeze beats everything. A flush beats load-use
  // because the instruction waiting in ID is on the wrong path.
  always_comb begin
    w_take_flush    = ~mem_stall & flush_EX;
    w_take_bubble   = ~mem_stall & ~flush_EX & w_lu;
    w_insert_bubble = w_take_flush | w_take_bubble;
    stall_PC        = mem_stall | (w_lu & ~flush_EX);
    stall_IFID      = mem_stall | (w_lu & ~flush_EX);
    flush_IFID      = flush_EX & ~mem_stall;
  end

  // Pipeline register: hold on freeze, zero on bubble, otherwise capture ID.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_have_inst <= 1'b0;
      r_pc        <= 32'd0;
      r_rD1       <= 32'd0;
      r_rD2       <= 32'd0;
      r_ext       <= 32'd0;
      r_wR        <= 5'd0;
      r_rf_we     <= 1'b0;
      r_rf_wsel   <= 3'd0;
      r_alu_op    <= 4'd0;
      r_alu_sel1  <= 1'b0;
      r_alu_sel2  <= 1'b0;
      r_dram_we   <= 1'b0;
      r_npc_op    <= 2'd0;
      r_store_op  <= 2'd0;
    end else if (!mem_stall) begin
      if (w_insert_bubble) begin
        r_have_inst <= 1'b0;
        r_pc        <= 32'd0;
        r_rD1       <= 32'd0;
        r_rD2       <= 32'd0;
        r_ext       <= 32'd0;
        r_wR        <= 5'd0;
        r_rf_we     <= 1'b0;
        r_rf_wsel   <= 3'd0;
        r_alu_op    <= 4'd0;
        r_alu_sel1  <= 1'b0;
        r_alu_sel2  <= 1'b0;
        r_dram_we   <= 1'b0;
        r_npc_op    <= 2'd0;
        r_store_op  <= 2'd0;
      end else begin
        r_have_inst <= have_inst_ID;
        r_pc        <= pc_ID;
        r_rD1       <= rD1_ID;
        r_rD2       <= rD2_ID;
        r_ext       <= ext_ID;
        r_wR        <= wR_ID;
        r_rf_we     <= rf_we_ID;
        r_rf_wsel   <= rf_wsel_ID;
        r_alu_op    <= alu_op_ID;
        r_alu_sel1  <= alu_sel1_ID;
        r_alu_sel2  <= alu_sel2_ID;
        r_dram_we   <= dram_we_ID;
        r_npc_op    <= npc_op_ID;
        r_store_op  <= store_op_ID;
      end
    end
  end

  // Saturating event counters; they stop at all-ones instead of wrapping.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_take_bubble && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      if (w_take_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Registered state drives the EX-side outputs directly.
  always_comb begin
    have_inst_EX = r_have_inst;
    pc_EX        = r_pc;
    rD1_EX       = r_rD1;
    rD2_EX       = r_rD2;
    ext_EX       = r_ext;
    wR_EX        = r_wR;
    rf_we_EX     = r_rf_we;
    rf_wsel_EX   = r_rf_wsel;
    alu_op_EX    = r_alu_op;
    alu_sel1_EX  = r_alu_sel1;
    alu_sel2_EX  = r_alu_sel2;
    dram_we_EX   = r_dram_we;
    npc_op_EX    = r_npc_op;
    store_op_EX  = r_store_op;
    bubble_cnt   = r_bubble_cnt;
    flush_cnt    = r_flush_cnt;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Inputs are driven 1 time unit after
// the rising edge, and outputs are sampled before the next edge.
module tb_id_ex_stage;
  localparam int CNT_W = 16;

  logic             cpu_clk = 1'b0;
  logic             cpu_rst;
  logic             have_inst_ID;
  logic [31:0]      pc_ID, rD1_ID, rD2_ID, ext_ID;
  logic [4:0]       rs1_ID, rs2_ID, wR_ID;
  logic             rs1_re_ID, rs2_re_ID, rf_we_ID;
  logic [2:0]       rf_wsel_ID;
  logic [3:0]       alu_op_ID;
  logic             alu_sel1_ID, alu_sel2_ID, dram_we_ID;
  logic [1:0]       npc_op_ID, store_op_ID;
  logic             flush_EX, mem_stall;
  logic             have_inst_EX;
  logic [31:0]      pc_EX, rD1_EX, rD2_EX, ext_EX;
  logic [4:0]       wR_EX;
  logic             rf_we_EX;
  logic [2:0]       rf_wsel_EX;
  logic [3:0]       alu_op_EX;
  logic             alu_sel1_EX, alu_sel2_EX, dram_we_EX;
  logic [1:0]       npc_op_EX, store_op_EX;
  logic             stall_PC, stall_IFID, flush_IFID;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 cpu_clk = ~cpu_clk;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .have_inst_ID(have_inst_ID), .pc_ID(pc_ID), .rD1_ID(rD1_ID), .rD2_ID(rD2_ID),
    .ext_ID(ext_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .wR_ID(wR_ID),
    .rs1_re_ID(rs1_re_ID), .rs2_re_ID(rs2_re_ID), .rf_we_ID(rf_we_ID),
    .rf_wsel_ID(rf_wsel_ID), .alu_op_ID(alu_op_ID), .alu_sel1_ID(alu_sel1_ID),
    .alu_sel2_ID(alu_sel2_ID), .dram_we_ID(dram_we_ID), .npc_op_ID(npc_op_ID),
    .store_op_ID(store_op_ID), .flush_EX(flush_EX), .mem_stall(mem_stall),
    .have_inst_EX(have_inst_EX), .pc_EX(pc_EX), .rD1_EX(rD1_EX), .rD2_EX(rD2_EX),
    .ext_EX(ext_EX), .wR_EX(wR_EX), .rf_we_EX(rf_we_EX), .rf_wsel_EX(rf_wsel_EX),
    .alu_op_EX(alu_op_EX), .alu_sel1_EX(alu_sel1_EX), .alu_sel2_EX(alu_sel2_EX),
    .dram_we_EX(dram_we_EX), .npc_op_EX(npc_op_EX), .store_op_EX(store_op_EX),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .flush_IFID(flush_IFID),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  // Drive a simple instruction into ID. Data fields are derived from the PC,
  // and the remaining control fields are zero.
  task automatic set_inst(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] wr, input logic re1, input logic re2,
                          input logic we, input logic [2:0] wsel);
    have_inst_ID = 1'b1;
    pc_ID = pc; rD1_ID = pc ^ 32'h1111_0000; rD2_ID = pc ^ 32'h0000_2222; ext_ID = pc + 32'd4;
    rs1_ID = rs1; rs2_ID = rs2; wR_ID = wr; rs1_re_ID = re1; rs2_re_ID = re2;
    rf_we_ID = we; rf_wsel_ID = wsel; alu_op_ID = 4'd0; alu_sel1_ID = 1'b0;
    alu_sel2_ID = 1'b0; dram_we_ID = 1'b0; npc_op_ID = 2'd0; store_op_ID = 2'd0;
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; mem_stall = 1'b1; flush_EX = 1'b0;
    set_inst(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    have_inst_ID = 1'b0;
    #3;
    cmp_cnt++; if (have_inst_EX !== 1'b0) begin err_cnt++; $display("FAIL rst_have: got %b want 0", have_inst_EX); end
    cmp_cnt++; if (pc_EX !== 32'd0) begin err_cnt++; $display("FAIL rst_pc: got %h want 0", pc_EX); end
    cmp_cnt++; if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) begin err_cnt++; $display("FAIL rst_cnt: got %h/%h want 0/0", bubble_cnt, flush_cnt); end
    cmp_cnt++; if (stall_PC !== 1'b1 || stall_IFID !== 1'b1) begin err_cnt++; $display("FAIL rst_stall_follows_mem: got %b%b want 11", stall_PC, stall_IFID); end
    mem_stall = 1'b0;
    #1;
    cmp_cnt++; if (stall_PC !== 1'b0 || flush_IFID !== 1'b0) begin err_cnt++; $display("FAIL rst_idle: got stall %b flush %b want 0 0", stall_PC, flush_IFID); end
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    step();
  endtask

  task automatic test_pass_through();
    have_inst_ID = 1'b1; pc_ID = 32'h0000_0100; rD1_ID = 32'hDEAD_BEEF; rD2_ID = 32'h1234_5678;
    ext_ID = 32'hFFFF_FFF0; rs1_ID = 5'd3; rs2_ID = 5'd4; wR_ID = 5'd9; rs1_re_ID = 1'b1;
    rs2_re_ID = 1'b1; rf_we_ID = 1'b1; rf_wsel_ID = 3'b001; alu_op_ID = 4'hA;
    alu_sel1_ID = 1'b1; alu_sel2_ID = 1'b1; dram_we_ID = 1'b1; npc_op_ID = 2'b10; store_op_ID = 2'b11;
    step();
    cmp_cnt++; if (have_inst_EX !== 1'b1 || pc_EX !== 32'h100) begin err_cnt++; $display("FAIL pass_pc: got %b %h want 1 00000100", have_inst_EX, pc_EX); end
    cmp_cnt++; if (rD1_EX !== 32'hDEAD_BEEF || rD2_EX !== 32'h1234_5678 || ext_EX !== 32'hFFFF_FFF0) begin err_cnt++; $display("FAIL pass_data: got %h %h %h", rD1_EX, rD2_EX, ext_EX); end
    cmp_cnt++; if ({wR_EX, rf_we_EX, rf_wsel_EX, alu_op_EX} !== {5'd9, 1'b1, 3'b001, 4'hA}) begin err_cnt++; $display("FAIL pass_ctl_a: got %h %b %b %h", wR_EX, rf_we_EX, rf_wsel_EX, alu_op_EX); end
    cmp_cnt++; if ({alu_sel1_EX, alu_sel2_EX, dram_we_EX, npc_op_EX, store_op_EX} !== 7'b111_10_11) begin err_cnt++; $display("FAIL pass_ctl_b: got %b%b%b %b %b want 111 10 11", alu_sel1_EX, alu_sel2_EX, dram_we_EX, npc_op_EX, store_op_EX); end
  endtask

  task automatic test_load_use();
    set_inst(32'h200, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 3'b010);  // lw x5
    step();
    set_inst(32'h204, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 3'b000);  // add x6,x5,x1
    #1;
    cmp_cnt++; if (stall_PC !== 1'b1 || stall_IFID !== 1'b1 || flush_IFID !== 1'b0) begin err_cnt++; $display("FAIL lu_stall: got %b%b%b want 110", stall_PC, stall_IFID, flush_IFID); end
    step();
    cmp_cnt++; if (have_inst_EX !== 1'b0 || pc_EX !== 32'd0 || rf_we_EX !== 1'b0) begin err_cnt++; $display("FAIL lu_bubble: got %b %h %b want 0 0 0", have_inst_EX, pc_EX, rf_we_EX); end
    cmp_cnt++; if (bubble_cnt !== 16'd1) begin err_cnt++; $display("FAIL lu_bubble_cnt: got %0d want 1", bubble_cnt); end
    cmp_cnt++; if (stall_PC !== 1'b0) begin err_cnt++; $display("FAIL lu_one_cycle: got stall %b want 0", stall_PC); end
    step();
    cmp_cnt++; if (have_inst_EX !== 1'b1 || pc_EX !== 32'h204 || wR_EX !== 5'd6) begin err_cnt++; $display("FAIL lu_advance: got %b %h %0d want 1 204 6", have_inst_EX, pc_EX, wR_EX); end
  endtask

  task automatic test_no_hazard();
    set_inst(32'h300, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 3'b100);  // load to x0
    step();
    set_inst(32'h304, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 3'b000);
    #1;
    cmp_cnt++; if (stall_PC !== 1'b0) begin err_cnt++; $display("FAIL nh_x0: got stall %b want 0", stall_PC); end
    set_inst(32'h308, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 3'b010);  // lw x5
    step();
    set_inst(32'h30C, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 3'b000);  // lui x5
    #1;
    cmp_cnt++; if (stall_PC !== 1'b0 || stall_IFID !== 1'b0) begin err_cnt++; $display("FAIL nh_unused_src: got %b%b want 00", stall_PC, stall_IFID); end
    step();
    set_inst(32'h310, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 3'b000);  // lui x5 in EX is not a load
    #1;
    cmp_cnt++; if (stall_PC !== 1'b0) begin err_cnt++; $display("FAIL nh_non_load: got stall %b want 0", stall_PC); end
    set_inst(32'h314, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 3'b111);  // load x7, wsel 111
    step();
    set_inst(32'h318, 5'd2, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 3'b000);  // store reads x7 via rs2
    #1;
    cmp_cnt++; if (stall_PC !== 1'b1) begin err_cnt++; $display("FAIL lu_rs2: got stall %b want 1", stall_PC); end
    step();
    cmp_cnt++; if (bubble_cnt !== 16'd2 || have_inst_EX !== 1'b0) begin err_cnt++; $display("FAIL lu_rs2_bubble: got cnt %0d have %b want 2 0", bubble_cnt, have_inst_EX); end
    step();
    cmp_cnt++; if (pc_EX !== 32'h318) begin err_cnt++; $display("FAIL lu_rs2_advance: got %h want 00000318", pc_EX); end
  endtask

  task automatic test_flush_over_lu();
    set_inst(32'h400, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 3'b101);
    step();
    set_inst(32'h404, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 3'b000);
    flush_EX = 1'b1;
    #1;
    cmp_cnt++; if (flush_IFID !== 1'b1 || stall_PC !== 1'b0 || stall_IFID !== 1'b0) begin err_cnt++; $display("FAIL flu_outputs: got flush %b stall %b%b want 1 00", flush_IFID, stall_PC, stall_IFID); end
    step();
    flush_EX = 1'b0;
    cmp_cnt++; if (have_inst_EX !== 1'b0 || pc_EX !== 32'd0) begin err_cnt++; $display("FAIL flu_bubble: got %b %h want 0 0", have_inst_EX, pc_EX); end
    cmp_cnt++; if (flush_cnt !== 16'd1 || bubble_cnt !== 16'd2) begin err_cnt++; $display("FAIL flu_cnts: got flush %0d bubble %0d want 1 2", flush_cnt, bubble_cnt); end
  endtask

  task automatic test_freeze();
    set_inst(32'h500, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 3'b000);
    step();
    set_inst(32'h504, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 3'b000);
    mem_stall = 1'b1; flush_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp_cnt++; if (flush_IFID !== 1'b0 || stall_PC !== 1'b1) begin err_cnt++; $display("FAIL frz_out[%0d]: got flush %b stall %b want 0 1", i, flush_IFID, stall_PC); end
      step();
      cmp_cnt++; if (have_inst_EX !== 1'b1 || pc_EX !== 32'h500 || flush_cnt !== 16'd1) begin err_cnt++; $display("FAIL frz_hold[%0d]: got %b %h cnt %0d want 1 500 1", i, have_inst_EX, pc_EX, flush_cnt); end
    end
    mem_stall = 1'b0;
    #1;
    cmp_cnt++; if (flush_IFID !== 1'b1 || stall_PC !== 1'b0) begin err_cnt++; $display("FAIL frz_release: got flush %b stall %b want 1 0", flush_IFID, stall_PC); end
    step();
    cmp_cnt++; if (have_inst_EX !== 1'b0 || pc_EX !== 32'd0 || flush_cnt !== 16'd2) begin err_cnt++; $display("FAIL frz_flush_taken: got %b %h cnt %0d want 0 0 2", have_inst_EX, pc_EX, flush_cnt); end
  endtask

  task automatic test_saturation();
    // flush_EX is still asserted, and flush_cnt is 2 here.
    repeat (16'hFFFC) @(posedge cpu_clk);
    #1;
    cmp_cnt++; if (flush_cnt !== 16'hFFFE) begin err_cnt++; $display("FAIL sat_preload: got %h want fffe", flush_cnt); end
    for (int i = 0; i < 3; i++) begin
      step();
      cmp_cnt++; if (flush_cnt !== 16'hFFFF) begin err_cnt++; $display("FAIL sat_hold[%0d]: got %h want ffff", i, flush_cnt); end
    end
    flush_EX = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    set_inst(32'h600, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 3'b110);
    step();
    set_inst(32'h604, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 3'b000);
    #1;
    cmp_cnt++; if (stall_PC !== 1'b1) begin err_cnt++; $display("FAIL rmid_pre: got stall %b want 1", stall_PC); end
    #1 cpu_rst = 1'b1;
    #1;
    cmp_cnt++; if (have_inst_EX !== 1'b0 || pc_EX !== 32'd0 || rf_wsel_EX !== 3'd0) begin err_cnt++; $display("FAIL rmid_ex: got %b %h %b want 0 0 000", have_inst_EX, pc_EX, rf_wsel_EX); end
    cmp_cnt++; if (flush_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin err_cnt++; $display("FAIL rmid_cnt: got %h %h want 0 0", flush_cnt, bubble_cnt); end
    cmp_cnt++; if (stall_PC !== 1'b0) begin err_cnt++; $display("FAIL rmid_stall: got %b want 0", stall_PC); end
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    step();
    cmp_cnt++; if (pc_EX !== 32'h604 || have_inst_EX !== 1'b1) begin err_cnt++; $display("FAIL rmid_after: got %h %b want 604 1", pc_EX, have_inst_EX); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_hazard();
    test_flush_over_lu();
    test_freeze();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the five-stage RV32I core. It captures the decoded control bundle from the ID-stage decoder, along with operands, immediate, PC and destination register, and presents them to EX one cycle later. It detects load-use hazards and inserts exactly one bubble for each. It converts a taken branch or jump resolved in EX into a bubble plus an IF/ID flush, and it keeps saturating hazard counters for performance debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the bubble and flush counters.

Ports:
- `cpu_clk`  in  1  core clock; all state updates on the rising edge.
- `cpu_rst`  in  1  asynchronous, active-high reset.
- `have_inst_ID`  in  1  ID holds a valid decoded instruction.
- `pc_ID`, `rD1_ID`, `rD2_ID`, `ext_ID`  in  32 each  PC, register-file reads, sign-extended immediate.
- `rs1_ID`, `rs2_ID`, `wR_ID`  in  5 each  source and destination register numbers.
- `rs1_re_ID`, `rs2_re_ID`  in  1 each  instruction actually reads rs1 / rs2.
- `rf_we_ID`  in  1  register-file write enable from the decoder.
- `rf_wsel_ID`  in  3  writeback source select.
- `alu_op_ID`  in  4  ALU operation.
- `alu_sel1_ID`, `alu_sel2_ID`  in  1 each  ALU operand selects.
- `dram_we_ID`  in  1  data-memory write enable.
- `npc_op_ID`  in  2  next-PC operation.
- `store_op_ID`  in  2  store width.
- `flush_EX`  in  1  taken branch or jump resolved in EX this cycle.
- `mem_stall`  in  1  global freeze request from the data-memory side.
- `*_EX`  out  same widths as the matching `*_ID` inputs  registered copies: `have_inst_EX`, `pc_EX`, `rD1_EX`, `rD2_EX`, `ext_EX`, `wR_EX`, `rf_we_EX`, `rf_wsel_EX`, `alu_op_EX`, `alu_sel1_EX`, `alu_sel2_EX`, `dram_we_EX`, `npc_op_EX`, `store_op_EX`.
- `stall_PC`, `stall_IFID`  out  1 each  hold the PC and the IF/ID register.
- `flush_IFID`  out  1  invalidate the IF/ID register at the next edge.
- `bubble_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters.

## Operation
- **Load in EX:** `ld_EX` = `have_inst_EX` & `rf_we_EX` & (`rf_wsel_EX` ∈ {010, 100, 101, 110, 111}).
- **Load-use hazard:** `lu` = `ld_EX` & `have_inst_ID` & `wR_EX` ≠ 0 & ((`rs1_re_ID` & `rs1_ID` == `wR_EX`) | (`rs2_re_ID` & `rs2_ID` == `wR_EX`)).
- **Bubble value:** all `*_EX` = 0. This includes `npc_op` = 00 (PC+4), `rf_we` = 0, `dram_we` = 0 and `have_inst` = 0.
- **Next-state priority, per edge:**
  1. `mem_stall`=1: register holds; counters hold.
  2. `flush_EX`=1: load bubble; `flush_cnt` += 1.
  3. `lu`=1: load bubble; `bubble_cnt` += 1.
  4. Otherwise: load all `*_ID` inputs.
- **Combinational outputs:**
  - `stall_PC` = `stall_IFID` = `mem_stall` | (`lu` & ~`flush_EX`).
  - `flush_IFID` = `flush_EX` & ~`mem_stall`.
- **Flush over load-use:** a flush suppresses the stall, because the ID instruction is on the wrong path.
- **Counters:** saturate at all-ones and never wrap.
- **Single bubble per hazard:** after a bubble, `ld_EX`=0, so `lu` clears and the held ID instruction advances on the following edge.
- **x0 destination:** a load to x0 never causes a stall.

## Timing
- **Reset:** `cpu_rst`=1 immediately forces every `*_EX` output and both counters to 0, regardless of clock. `stall_*` and `flush_IFID` then follow their equations, which evaluate to `mem_stall`.
- **Reset release:** registers update normally from the first rising edge after deassertion.
- **Latency:** ID to EX is one cycle.
- **Hazard outputs:** `stall_*` and `flush_IFID` are purely combinational, valid in the same cycle as `lu` / `flush_EX`. They have no registered delay.
- **Reset mid-stall:** any pending hazard is dropped. After reset, EX holds a bubble and no stall is outstanding.
- **Simultaneous `flush_EX` and `mem_stall`:** freeze wins. `flush_EX` must stay asserted by its source until `mem_stall` falls, and the flush is taken on that edge.

## Test plan
- **Reset:** drive `cpu_rst`=1 mid-cycle with non-zero EX contents → all `*_EX` outputs and both counters read 0 before the next edge.
- **Load-use:** `lw x5` in EX (`rf_wsel_EX`=010, `wR_EX`=5); `add x6,x5,x1` in ID with `rs1_re_ID`=1 → `stall_PC`=`stall_IFID`=1 for exactly one cycle. Next cycle EX is a bubble, `bubble_cnt`=1, and on the cycle after that the `add` appears in EX.
- **No hazard (unused source / x0):** `lw x0` in EX with any ID instruction → no stall. `lw x5` in EX with `lui x5` in ID (`rs1_re_ID`=`rs2_re_ID`=0) → no stall.
- **Flush beats load-use:** `flush_EX`=1 and `lu`=1 in the same cycle → `flush_IFID`=1, `stall_*`=0; EX loads a bubble; `flush_cnt`=1, `bubble_cnt` unchanged.
- **Freeze:** `mem_stall`=1 for 3 cycles with `flush_EX`=1 → `*_EX` unchanged and `flush_IFID`=0 throughout. On the edge after `mem_stall` falls, EX becomes a bubble.
- **Saturation:** preload 0xFFFE flush events, then apply 3 more → `flush_cnt` = 0xFFFF and stays there.
